uart_tx_serializer: RTL and testbench

Transmit serializer for the APB UART. It reads characters one at a time from the TX FIFO and shifts each one out on TXD as an asynchronous serial frame: start bit, 5–8 data bits LSB first, optional parity, then 1, 1.5 or 2 stop bits. The FIFO is the usual library FIFO, which has a registered Q and a registered EMPTY flag. Bit timing comes from the shared 16x baud-enable strobe, BAUDCE. The UART register file drives the line-control inputs and reads back BUSY.

---
 rtl/uart_tx_serializer.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops characters from the TX FIFO and shifts each one
// out on TXD as start bit, 5-8 data bits LSB first, optional parity and 1/1.5/2
// stop bits, timed by a 16x baud-enable strobe.
module uart_tx_serializer (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CLEAR,
  input  logic       BAUDCE,
  input  logic [1:0] WLS,
  input  logic       STB,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       SP,
  input  logic       BC,
  input  logic       FIFO_EMPTY,
  input  logic [7:0] FIFO_Q,
  output logic       FIFO_READ,
  output logic       TXD,
  output logic       BUSY,
  output logic       FRAME_DONE
);

  typedef enum logic [2:0] {
    StIdle, StPop, StWait, StStart, StData, StParity, StStop
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [2:0]  bit_q, bit_d;
  logic [4:0]  tick_q, tick_d;
  logic [1:0]  wls_q, wls_d;
  logic        stb_q, stb_d;
  logic        pen_q, pen_d;
  logic        parity_q, parity_d;
  logic        txd_q, txd_d;
  logic        level;
  logic [7:0]  word_mask;
  logic        data_xor;
  logic [4:0]  stop_last;
  logic [2:0]  last_bit;

  // Parity over only the bits that will actually be sent, from the live line control.
  always_comb begin
    word_mask = 8'hff;
    unique case (WLS)
      2'b00:   word_mask = 8'h1f;
      2'b01:   word_mask = 8'h3f;
      2'b10:   word_mask = 8'h7f;
      default: word_mask = 8'hff;
    endcase
    data_xor = ^(FIFO_Q & word_mask);
  end

  // Final tick index of STOP and of the data phase, from the held frame settings.
  always_comb begin
    if (!stb_q)              stop_last = 5'd15;
    else if (wls_q == 2'b00) stop_last = 5'd23;
    else                     stop_last = 5'd31;
    last_bit = {1'b0, wls_q} + 3'd4;
  end

  // Next-state, counters and strobes; CLEAR overrides everything.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_d      = bit_q;
    tick_d     = tick_q;
    wls_d      = wls_q;
    stb_d      = stb_q;
    pen_d      = pen_q;
    parity_d   = parity_q;
    FIFO_READ  = 1'b0;
    FRAME_DONE = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!FIFO_EMPTY) state_d = StPop;
      end
      StPop: begin
        FIFO_READ = 1'b1;
        state_d   = StWait;
      end
      StWait: begin
        shreg_d  = FIFO_Q;
        bit_d    = 3'd0;
        tick_d   = 5'd0;
        wls_d    = WLS;
        stb_d    = STB;
        pen_d    = PEN;
        parity_d = SP ? ~EPS : (EPS ? data_xor : ~data_xor);
        state_d  = StStart;
      end
      StStart: begin
        if (BAUDCE) begin
          if (tick_q == 5'd15) begin
            tick_d  = 5'd0;
            state_d = StData;
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
      StData: begin
        if (BAUDCE) begin
          if (tick_q == 5'd15) begin
            tick_d = 5'd0;
            if (bit_q == last_bit) begin
              state_d = pen_q ? StParity : StStop;
            end else begin
              shreg_d = shreg_q >> 1;
              bit_d   = bit_q + 3'd1;
            end
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
      StParity: begin
        if (BAUDCE) begin
          if (tick_q == 5'd15) begin
            tick_d  = 5'd0;
            state_d = StStop;
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
      StStop: begin
        if (BAUDCE) begin
          if (tick_q == stop_last) begin
            tick_d     = 5'd0;
            FRAME_DONE = 1'b1;
            state_d    = FIFO_EMPTY ? StIdle : StPop;
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (CLEAR) begin
      state_d    = StIdle;
      tick_d     = 5'd0;
      bit_d      = 3'd0;
      FIFO_READ  = 1'b0;
      FRAME_DONE = 1'b0;
    end
  end

  // Line level follows the next state so TXD lands one register stage after it.
  always_comb begin
    level = 1'b1;
    case (state_d)
      StStart:  level = 1'b0;
      StData:   level = shreg_d[0];
      StParity: level = parity_d;
      default:  level = 1'b1;
    endcase
    txd_d = BC ? 1'b0 : level;
  end

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      shreg_q  <= 8'd0;
      bit_q    <= 3'd0;
      tick_q   <= 5'd0;
      wls_q    <= 2'd0;
      stb_q    <= 1'b0;
      pen_q    <= 1'b0;
      parity_q <= 1'b0;
      txd_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bit_q    <= bit_d;
      tick_q   <= tick_d;
      wls_q    <= wls_d;
      stb_q    <= stb_d;
      pen_q    <= pen_d;
      parity_q <= parity_d;
      txd_q    <= txd_d;
    end
  end

  assign TXD  = txd_q;
  assign BUSY = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed self-checking bench for uart_tx_serializer with a small FIFO model.
module tb_uart_tx_serializer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CLEAR = 1'b0;
  logic       BAUDCE = 1'b1;
  logic [1:0] WLS = 2'b11;
  logic       STB = 1'b0;
  logic       PEN = 1'b0;
  logic       EPS = 1'b0;
  logic       SP = 1'b0;
  logic       BC = 1'b0;
  logic       FIFO_EMPTY = 1'b1;
  logic [7:0] FIFO_Q = 8'h00;
  logic       FIFO_READ;
  logic       TXD;
  logic       BUSY;
  logic       FRAME_DONE;

  int errors = 0;
  int checks = 0;
  logic [7:0] fifo_mem[$];

  uart_tx_serializer dut (
    .CLK        (CLK),
    .RST        (RST),
    .CLEAR      (CLEAR),
    .BAUDCE     (BAUDCE),
    .WLS        (WLS),
    .STB        (STB),
    .PEN        (PEN),
    .EPS        (EPS),
    .SP         (SP),
    .BC         (BC),
    .FIFO_EMPTY (FIFO_EMPTY),
    .FIFO_Q     (FIFO_Q),
    .FIFO_READ  (FIFO_READ),
    .TXD        (TXD),
    .BUSY       (BUSY),
    .FRAME_DONE (FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  // FIFO model: registered Q and registered EMPTY flag; not affected by RST.
  always @(posedge CLK) begin
    if (FIFO_READ && fifo_mem.size() > 0) FIFO_Q <= fifo_mem.pop_front();
    FIFO_EMPTY <= (fifo_mem.size() == 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for the pop pulse, then check the WAIT cycle; exp_wait<0 means any delay.
  task automatic wait_pop(input string tag, input int exp_wait);
    int w = 0;
    @(negedge CLK);
    while (!FIFO_READ && w < 400) begin
      @(negedge CLK);
      w++;
    end
    chk({tag, "/pop"}, {31'd0, FIFO_READ}, 32'd1);
    if (exp_wait >= 0) chk({tag, "/pop_delay"}, w, exp_wait);
    chk({tag, "/pop_txd"}, {31'd0, TXD}, 32'd1);
    @(negedge CLK);
    chk({tag, "/wait_read"}, {31'd0, FIFO_READ}, 32'd0);
    chk({tag, "/wait_txd"}, {31'd0, TXD}, 32'd1);
    chk({tag, "/wait_busy"}, {31'd0, BUSY}, 32'd1);
  endtask

  task automatic hold(input string tag, input logic lvl, input int n, input bit done_last);
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      chk({tag, "/txd"}, {31'd0, TXD}, {31'd0, lvl});
      chk({tag, "/done"}, {31'd0, FRAME_DONE}, {31'd0, done_last && (k == n - 1)});
      chk({tag, "/busy"}, {31'd0, BUSY}, 32'd1);
      chk({tag, "/read"}, {31'd0, FIFO_READ}, 32'd0);
    end
  endtask

  task automatic frame_body(input string tag, input logic [7:0] data, input int nbits,
                            input bit pen, input logic par, input int stop_ticks);
    hold({tag, "/start"}, 1'b0, 16, 1'b0);
    for (int b = 0; b < nbits; b++) hold({tag, "/data"}, data[b], 16, 1'b0);
    if (pen) hold({tag, "/parity"}, par, 16, 1'b0);
    hold({tag, "/stop"}, 1'b1, stop_ticks, 1'b1);
  endtask

  task automatic frame(input string tag, input int exp_wait, input logic [7:0] data,
                       input int nbits, input bit pen, input logic par, input int stop_ticks);
    wait_pop(tag, exp_wait);
    frame_body(tag, data, nbits, pen, par, stop_ticks);
  endtask

  task automatic chk_idle(input string tag);
    @(negedge CLK);
    chk({tag, "/idle_busy"}, {31'd0, BUSY}, 32'd0);
    chk({tag, "/idle_txd"}, {31'd0, TXD}, 32'd1);
    chk({tag, "/idle_read"}, {31'd0, FIFO_READ}, 32'd0);
    chk({tag, "/idle_done"}, {31'd0, FRAME_DONE}, 32'd0);
  endtask

  initial begin
    logic [7:0] b12;
    b12 = 8'h12;
    // Reset state
    repeat (3) @(negedge CLK);
    chk("reset/txd", {31'd0, TXD}, 32'd1);
    chk("reset/busy", {31'd0, BUSY}, 32'd0);
    chk("reset/read", {31'd0, FIFO_READ}, 32'd0);
    chk("reset/done", {31'd0, FRAME_DONE}, 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    // 8N1 0x55: push, then IDLE for one cycle, then POP
    fifo_mem.push_back(8'h55);
    frame("8n1_55", 1, 8'h55, 8, 1'b0, 1'b0, 16);
    chk_idle("8n1_55");

    // 5 bits, even parity, 1.5 stop: 0x1B -> 1,1,0,1,1, parity 0, 24 stop ticks
    WLS = 2'b00; PEN = 1'b1; EPS = 1'b1; STB = 1'b1;
    fifo_mem.push_back(8'h1B);
    frame("5e15_1b", -1, 8'h1B, 5, 1'b1, 1'b0, 24);
    chk_idle("5e15_1b");

    // Same byte, odd parity, 1 stop: parity 1
    EPS = 1'b0; STB = 1'b0;
    fifo_mem.push_back(8'h1B);
    frame("5o1_1b", -1, 8'h1B, 5, 1'b1, 1'b1, 16);
    chk_idle("5o1_1b");

    // Two queued bytes, 8N2: second frame pops right after the first stop
    WLS = 2'b11; PEN = 1'b0; STB = 1'b1;
    fifo_mem.push_back(8'hA3);
    fifo_mem.push_back(8'h0F);
    frame("8n2_a3", -1, 8'hA3, 8, 1'b0, 1'b0, 32);
    frame("8n2_0f", 0, 8'h0F, 8, 1'b0, 1'b0, 32);
    chk_idle("8n2_end");
    repeat (4) @(negedge CLK);
    chk("8n2_end/no_extra_pop", {31'd0, FIFO_READ}, 32'd0);
    chk("8n2_end/empty", {31'd0, FIFO_EMPTY}, 32'd1);

    // Break asserted in data bit 2 of 0xFF 8N1; frame still completes on time
    STB = 1'b0;
    fifo_mem.push_back(8'hFF);
    wait_pop("brk", -1);
    for (int i = 1; i <= 160; i++) begin
      @(negedge CLK);
      chk("brk/txd", {31'd0, TXD}, {31'd0, (i > 16) && (i <= 52)});
      chk("brk/done", {31'd0, FRAME_DONE}, {31'd0, i == 160});
      if (i == 52) BC = 1'b1;
      if (i == 160) BC = 1'b0;
    end
    chk_idle("brk");

    // CLEAR in data bit 3 of 0x12 with 0x34 still queued
    fifo_mem.push_back(8'h12);
    fifo_mem.push_back(8'h34);
    wait_pop("clr", -1);
    for (int i = 1; i <= 70; i++) begin
      @(negedge CLK);
      chk("clr/txd", {31'd0, TXD}, {31'd0, (i > 16) && b12[(i - 17) / 16]});
      chk("clr/done", {31'd0, FRAME_DONE}, 32'd0);
    end
    CLEAR = 1'b1;
    @(negedge CLK);
    CLEAR = 1'b0;
    chk("clr/busy", {31'd0, BUSY}, 32'd0);
    chk("clr/txd_hi", {31'd0, TXD}, 32'd1);
    chk("clr/done_lo", {31'd0, FRAME_DONE}, 32'd0);
    chk("clr/read_lo", {31'd0, FIFO_READ}, 32'd0);
    frame("clr_34", 0, 8'h34, 8, 1'b0, 1'b0, 16);
    chk_idle("clr_34");

    // RST in STOP of 0x5A with 0x3C queued
    fifo_mem.push_back(8'h5A);
    fifo_mem.push_back(8'h3C);
    wait_pop("rst", -1);
    for (int i = 1; i <= 150; i++) @(negedge CLK);
    chk("rst/pre_busy", {31'd0, BUSY}, 32'd1);
    chk("rst/pre_txd", {31'd0, TXD}, 32'd1);
    #2 RST = 1'b1;
    #1;
    chk("rst/async_txd", {31'd0, TXD}, 32'd1);
    chk("rst/async_busy", {31'd0, BUSY}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    frame("rst_3c", 0, 8'h3C, 8, 1'b0, 1'b0, 16);
    chk_idle("rst_3c");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
